// File: rtl/apb_master_multi.sv
// ---------------------------------------------------------------------------
// apb_master_multi
//
// APB4 master for a bus shared by NUM_SLV slaves. A local command port
// (valid/ready) supplies one transfer at a time. The slave is chosen by the
// top address bits, and each slave has its own one-hot PSEL line. The block
// adds byte strobes, PSLVERR reporting, a wait-state timeout with abort, and
// back-to-back transfers with no idle cycle. Every transfer, including an
// illegal one, produces one registered response pulse.
//
// Ports
//   pclk, prst            clock and synchronous active-high reset
//   trf_valid/trf_ready   request handshake; trf_ready is combinational
//                         from pready of the selected slave while in ACCESS
//   trf_enc               2'b01 write, 2'b10 read; any other value is
//                         answered with an error response and no bus activity
//   trf_addr/wdata/strb   request payload
//   trf_rsp_valid/err     one-cycle response pulse with its error flag
//   trf_rdata             read data, qualified by trf_rsp_valid
//   psel..pstrb           APB request outputs
//   prdata/pready/pslverr per-slave APB returns; prdata is flattened, with
//                         slave i at [i*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
module apb_master_multi #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                      pclk,
    input  logic                      prst,
    input  logic                      trf_valid,
    output logic                      trf_ready,
    input  logic [1:0]                trf_enc,
    input  logic [ADDR_W-1:0]         trf_addr,
    input  logic [DATA_W-1:0]         trf_wdata,
    input  logic [DATA_W/8-1:0]       trf_strb,
    output logic                      trf_rsp_valid,
    output logic                      trf_rsp_err,
    output logic [DATA_W-1:0]         trf_rdata,
    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    output logic [DATA_W/8-1:0]       pstrb,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr
);

    localparam int SLV_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // The abort is taken on the wait cycle that would bring the counter up to TIMEOUT.
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [SLV_W-1:0]   idx;        // slave of the transfer in flight
    logic [SLV_W-1:0]   addr_idx;   // slave decoded from the incoming request
    logic [CNT_W-1:0]   wait_cnt;
    logic               pend_err;   // illegal request taken on a completion edge

    logic               pready_sel;
    logic               pslverr_sel;
    logic [DATA_W-1:0]  prdata_sel;
    logic [NUM_SLV-1:0] sel_onehot;

    logic               accept;
    logic               enc_legal;
    logic               take;
    logic               bad;
    logic               done;
    logic               abort;

    // ------------------------------------------------------------------
    // Slave decode and return-path mux
    // ------------------------------------------------------------------
    generate
        if (NUM_SLV == 1) begin : g_one
            assign addr_idx    = '0;
            assign pready_sel  = pready[0];
            assign pslverr_sel = pslverr[0];
            assign prdata_sel  = prdata;
        end else begin : g_many
            logic [DATA_W-1:0] prdata_arr [NUM_SLV];
            for (genvar g = 0; g < NUM_SLV; g++) begin : g_rd
                assign prdata_arr[g] = prdata[g*DATA_W +: DATA_W];
            end
            assign addr_idx    = trf_addr[ADDR_W-1 -: SLV_W];
            assign pready_sel  = pready[idx];
            assign pslverr_sel = pslverr[idx];
            assign prdata_sel  = prdata_arr[idx];
        end
    endgenerate

    assign sel_onehot = NUM_SLV'(1) << idx;

    assign accept    = trf_valid & trf_ready;
    assign enc_legal = (trf_enc == 2'b01) || (trf_enc == 2'b10);
    assign take      = accept & enc_legal;
    assign bad       = accept & ~enc_legal;
    assign done      = (state == ACCESS) & pready_sel;
    assign abort     = (TIMEOUT != 0) && (state == ACCESS) && !pready_sel
                       && (wait_cnt == TO_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (prst) state <= IDLE;
        else      state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (take) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS: begin
                if (pready_sel)  state_nxt = take ? SETUP : IDLE;
                else if (abort)  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. In ACCESS, ready follows pready so that the next
    // request can be taken on the completion edge. An abort happens only
    // while pready is low, so ready is already low on that cycle.
    // ------------------------------------------------------------------
    always_comb begin
        trf_ready = 1'b0;
        psel      = '0;
        penable   = 1'b0;
        unique case (state)
            IDLE:    trf_ready = ~pend_err;
            SETUP:   psel = sel_onehot;
            ACCESS: begin
                psel      = sel_onehot;
                penable   = 1'b1;
                trf_ready = pready_sel;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch. The bus outputs keep their last value between
    // transfers; only psel and penable drop in IDLE.
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (prst) begin
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
            pstrb  <= '0;
            idx    <= '0;
        end else if (take) begin
            paddr  <= trf_addr;
            pwrite <= (trf_enc == 2'b01);
            pwdata <= trf_wdata;
            pstrb  <= (trf_enc == 2'b01) ? trf_strb : STRB_W'(0);
            idx    <= addr_idx;
        end
    end

    // ------------------------------------------------------------------
    // Wait-state counter. It clears whenever a new SETUP begins.
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (prst)
            wait_cnt <= '0;
        else if (state_nxt == SETUP)
            wait_cnt <= '0;
        else if (state == ACCESS && !pready_sel)
            wait_cnt <= wait_cnt + 1'b1;
    end

    // An illegal request can be taken on a completion edge. The completion
    // response owns the next cycle, so the error response is sent one cycle
    // later, and trf_ready is held low in IDLE until it has gone out.
    always_ff @(posedge pclk) begin
        if (prst) pend_err <= 1'b0;
        else      pend_err <= (state == ACCESS) & pready_sel & bad;
    end

    // ------------------------------------------------------------------
    // Registered response channel
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (prst) begin
            trf_rsp_valid <= 1'b0;
            trf_rsp_err   <= 1'b0;
            trf_rdata     <= '0;
        end else begin
            trf_rsp_valid <= 1'b0;
            if (done) begin
                trf_rsp_valid <= 1'b1;
                trf_rsp_err   <= pslverr_sel;
                trf_rdata     <= pwrite ? '0 : prdata_sel;
            end else if (abort || pend_err || (state == IDLE && bad)) begin
                trf_rsp_valid <= 1'b1;
                trf_rsp_err   <= 1'b1;
                trf_rdata     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_multi.sv
module tb_apb_master_multi;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int NUM_SLV = 4;
    localparam int TIMEOUT = 16;

    logic                      pclk = 1'b0;
    logic                      prst;
    logic                      trf_valid;
    logic                      trf_ready;
    logic [1:0]                trf_enc;
    logic [ADDR_W-1:0]         trf_addr;
    logic [DATA_W-1:0]         trf_wdata;
    logic [DATA_W/8-1:0]       trf_strb;
    logic                      trf_rsp_valid;
    logic                      trf_rsp_err;
    logic [DATA_W-1:0]         trf_rdata;
    logic [NUM_SLV-1:0]        psel;
    logic                      penable;
    logic [ADDR_W-1:0]         paddr;
    logic                      pwrite;
    logic [DATA_W-1:0]         pwdata;
    logic [DATA_W/8-1:0]       pstrb;
    logic [NUM_SLV*DATA_W-1:0] prdata;
    logic [NUM_SLV-1:0]        pready;
    logic [NUM_SLV-1:0]        pslverr;

    int vecs = 0;
    int errs = 0;

    // Slave behaviour: the number of wait states, the read data, the error
    // flag, and whether the slave never answers.
    logic [3:0] cfg_waits [NUM_SLV];
    logic [7:0] cfg_rdata [NUM_SLV];
    logic       cfg_err   [NUM_SLV];
    logic       cfg_hang  [NUM_SLV];
    int         acc_cnt;

    always #5 pclk = ~pclk;

    apb_master_multi #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV), .TIMEOUT(TIMEOUT)
    ) dut (
        .pclk(pclk), .prst(prst),
        .trf_valid(trf_valid), .trf_ready(trf_ready), .trf_enc(trf_enc),
        .trf_addr(trf_addr), .trf_wdata(trf_wdata), .trf_strb(trf_strb),
        .trf_rsp_valid(trf_rsp_valid), .trf_rsp_err(trf_rsp_err), .trf_rdata(trf_rdata),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // Counts the ACCESS cycles of the current transfer.
    always @(posedge pclk) begin
        if (prst || !penable) acc_cnt <= 0;
        else                  acc_cnt <= acc_cnt + 1;
    end

    // Slaves that are not selected drive the opposite values, so a wrong
    // return-path mux shows up as an error.
    always_comb begin
        for (int i = 0; i < NUM_SLV; i++) begin
            pready[i]        = psel[i] ? (penable && !cfg_hang[i] && acc_cnt == int'(cfg_waits[i])) : 1'b1;
            pslverr[i]       = psel[i] ? cfg_err[i] : 1'b1;
            prdata[i*8 +: 8] = psel[i] ? cfg_rdata[i] : 8'hEE;
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_slave(input int s, input int w, input logic [7:0] rd, input logic e, input logic h);
        cfg_waits[s] = 4'(w);
        cfg_rdata[s] = rd;
        cfg_err[s]   = e;
        cfg_hang[s]  = h;
    endtask

    // Runs one isolated transfer. The expected results come from the
    // protocol rules: SETUP lasts one cycle, ACCESS lasts waits+1 cycles
    // (TIMEOUT cycles if the slave never answers), and the response arrives
    // 3+waits cycles after accept (2+TIMEOUT on abort, 1 for an illegal enc).
    task automatic do_xfer(input string name, input logic [1:0] enc, input logic [7:0] addr,
                           input logic [7:0] wdata, input logic strb);
        int s, exp_set, exp_acc, exp_lat, setups, accs, lat, n;
        logic legal, wr, exp_err, got, r_err, busok;
        logic [7:0] exp_rd, r_rd;
        logic [3:0] exp_psel;
        s        = int'(addr[7:6]);
        legal    = (enc == 2'b01) || (enc == 2'b10);
        wr       = (enc == 2'b01);
        exp_psel = 4'b0001 << s;
        if (!legal) begin
            exp_set = 0; exp_acc = 0; exp_lat = 1; exp_err = 1'b1; exp_rd = 8'h00;
        end else if (cfg_hang[s]) begin
            exp_set = 1; exp_acc = TIMEOUT; exp_lat = 2 + TIMEOUT; exp_err = 1'b1; exp_rd = 8'h00;
        end else begin
            exp_set = 1; exp_acc = int'(cfg_waits[s]) + 1; exp_lat = 3 + int'(cfg_waits[s]);
            exp_err = cfg_err[s]; exp_rd = wr ? 8'h00 : cfg_rdata[s];
        end

        trf_valid = 1'b1; trf_enc = enc; trf_addr = addr; trf_wdata = wdata; trf_strb = strb;
        n = 0;
        while (trf_ready !== 1'b1 && n < 50) begin tick(); n++; end
        vecs++;
        if (trf_ready !== 1'b1) begin
            errs++; $display("FAIL %s accept: trf_ready=%b required 1", name, trf_ready);
        end
        tick();
        // The payload is scrambled after accept to show that the DUT holds
        // its own copy.
        trf_valid = 1'b0; trf_enc = 2'($urandom); trf_addr = 8'($urandom);
        trf_wdata = 8'($urandom); trf_strb = 1'($urandom);

        setups = 0; accs = 0; lat = 0; got = 1'b0; r_err = 1'b0; r_rd = 8'h00;
        for (int k = 1; k <= 60 && !got; k++) begin
            if (psel !== 4'b0000) begin
                busok = (psel === exp_psel) && (paddr === addr) && (pwrite === wr)
                        && (pstrb === (wr ? strb : 1'b0)) && (!wr || pwdata === wdata);
                vecs++;
                if (!busok) begin
                    errs++;
                    $display("FAIL %s bus cyc%0d: psel=%b paddr=%h pwrite=%b pwdata=%h pstrb=%b required psel=%b paddr=%h pwrite=%b pwdata=%h pstrb=%b",
                             name, k, psel, paddr, pwrite, pwdata, pstrb, exp_psel, addr, wr, wdata, wr ? strb : 1'b0);
                end
                if (penable === 1'b1) accs++; else setups++;
            end
            if (trf_rsp_valid === 1'b1) begin
                got = 1'b1; lat = k; r_err = trf_rsp_err; r_rd = trf_rdata;
            end
            tick();
        end

        vecs++;
        if (setups != exp_set || accs != exp_acc) begin
            errs++; $display("FAIL %s phases: setup=%0d access=%0d required setup=%0d access=%0d",
                             name, setups, accs, exp_set, exp_acc);
        end
        vecs++;
        if (!got || lat != exp_lat) begin
            errs++; $display("FAIL %s latency: got=%b lat=%0d required lat=%0d", name, got, lat, exp_lat);
        end
        vecs++;
        if (r_err !== exp_err || r_rd !== exp_rd) begin
            errs++; $display("FAIL %s response: err=%b rdata=%h required err=%b rdata=%h",
                             name, r_err, r_rd, exp_err, exp_rd);
        end
        vecs++;
        if (trf_rsp_valid !== 1'b0 || psel !== 4'b0000 || penable !== 1'b0) begin
            errs++; $display("FAIL %s after: rsp_valid=%b psel=%b penable=%b required 0 0000 0",
                             name, trf_rsp_valid, psel, penable);
        end
    endtask

    task automatic test_reset();
        prst = 1'b1; trf_valid = 1'b0; trf_enc = 2'b00; trf_addr = '0; trf_wdata = '0; trf_strb = '0;
        for (int i = 0; i < NUM_SLV; i++) set_slave(i, 0, 8'h00, 1'b0, 1'b0);
        tick(); tick();
        vecs++;
        if ({psel, penable, paddr, pwrite, pwdata, pstrb, trf_rsp_valid, trf_rsp_err, trf_rdata} !== '0) begin
            errs++; $display("FAIL reset outputs: psel=%b penable=%b paddr=%h pwrite=%b pwdata=%h pstrb=%b rsp=%b err=%b rdata=%h required all 0",
                             psel, penable, paddr, pwrite, pwdata, pstrb, trf_rsp_valid, trf_rsp_err, trf_rdata);
        end
        vecs++;
        if (trf_ready !== 1'b1) begin
            errs++; $display("FAIL reset ready: trf_ready=%b required 1", trf_ready);
        end
        prst = 1'b0;
        tick();
    endtask

    task automatic test_write_zero_wait();
        set_slave(0, 0, 8'h11, 1'b0, 1'b0);
        do_xfer("wr_zero_wait", 2'b01, 8'h05, 8'hA5, 1'b1);
    endtask

    task automatic test_read_waits();
        set_slave(3, 3, 8'h3C, 1'b0, 1'b0);
        do_xfer("rd_wait3", 2'b10, 8'hC2, 8'h77, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] obs, req;
        set_slave(1, 0, 8'h99, 1'b0, 1'b0);
        set_slave(2, 0, 8'h7B, 1'b0, 1'b0);
        trf_valid = 1'b1; trf_enc = 2'b01; trf_addr = 8'h41; trf_wdata = 8'h5A; trf_strb = 1'b1;
        tick();                                   // write accepted, SETUP
        trf_enc = 2'b10; trf_addr = 8'h81; trf_wdata = 8'h00;
        vecs++;
        if ({psel, penable, trf_ready} !== {4'b0010, 1'b0, 1'b0}) begin
            errs++; $display("FAIL b2b setup1: psel=%b penable=%b ready=%b required 0010 0 0", psel, penable, trf_ready);
        end
        tick();                                   // ACCESS, slave ready
        vecs++;
        if ({psel, penable, trf_ready} !== {4'b0010, 1'b1, 1'b1}) begin
            errs++; $display("FAIL b2b access1: psel=%b penable=%b ready=%b required 0010 1 1", psel, penable, trf_ready);
        end
        tick();                                   // read accepted on completion edge
        trf_valid = 1'b0;
        obs = {psel, penable, paddr, pwrite, pstrb, trf_rsp_valid, trf_rsp_err, trf_rdata};
        req = {4'b0010 << 1, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs++;
        if (obs !== req) begin
            errs++; $display("FAIL b2b setup2: observed %h required %h", obs, req);
        end
        tick();
        vecs++;
        if ({psel, penable, trf_rsp_valid} !== {4'b0100, 1'b1, 1'b0}) begin
            errs++; $display("FAIL b2b access2: psel=%b penable=%b rsp=%b required 0100 1 0", psel, penable, trf_rsp_valid);
        end
        tick();
        vecs++;
        if ({psel, trf_rsp_valid, trf_rsp_err, trf_rdata} !== {4'b0000, 1'b1, 1'b0, 8'h7B}) begin
            errs++; $display("FAIL b2b rsp2: psel=%b rsp=%b err=%b rdata=%h required 0000 1 0 7b",
                             psel, trf_rsp_valid, trf_rsp_err, trf_rdata);
        end
        tick();
        vecs++;
        if (trf_rsp_valid !== 1'b0) begin
            errs++; $display("FAIL b2b end: rsp=%b required 0", trf_rsp_valid);
        end
    endtask

    task automatic test_pslverr();
        set_slave(2, 1, 8'h00, 1'b1, 1'b0);
        do_xfer("pslverr_wr", 2'b01, 8'h9A, 8'hC3, 1'b1);
        set_slave(2, 0, 8'h42, 1'b0, 1'b0);
        do_xfer("after_err_rd", 2'b10, 8'h90, 8'h00, 1'b0);
    endtask

    task automatic test_timeout();
        set_slave(3, 0, 8'h55, 1'b0, 1'b1);
        do_xfer("timeout_wr", 2'b01, 8'hF0, 8'h12, 1'b1);
        set_slave(3, 2, 8'h66, 1'b0, 1'b0);
        do_xfer("after_to_rd", 2'b10, 8'hF1, 8'h00, 1'b1);
    endtask

    task automatic test_illegal();
        do_xfer("illegal_11", 2'b11, 8'h44, 8'h01, 1'b1);
        do_xfer("illegal_00", 2'b00, 8'h84, 8'h02, 1'b0);
    endtask

    task automatic test_reset_mid_access();
        logic quiet;
        set_slave(1, 6, 8'h00, 1'b0, 1'b0);
        trf_valid = 1'b1; trf_enc = 2'b01; trf_addr = 8'h44; trf_wdata = 8'hBE; trf_strb = 1'b1;
        tick();
        trf_valid = 1'b0;
        tick();
        vecs++;
        if ({psel, penable} !== {4'b0010, 1'b1}) begin
            errs++; $display("FAIL rst_mid access: psel=%b penable=%b required 0010 1", psel, penable);
        end
        prst = 1'b1;
        tick();
        prst = 1'b0;
        vecs++;
        if ({psel, penable, paddr, pwrite, pwdata, pstrb, trf_rsp_valid, trf_rsp_err, trf_rdata} !== '0) begin
            errs++; $display("FAIL rst_mid outputs: psel=%b penable=%b paddr=%h pwdata=%h rsp=%b required all 0",
                             psel, penable, paddr, pwdata, trf_rsp_valid);
        end
        quiet = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (trf_rsp_valid !== 1'b0 || psel !== 4'b0000) quiet = 1'b0;
        end
        vecs++;
        if (!quiet) begin
            errs++; $display("FAIL rst_mid quiet: response or psel seen after reset, required none");
        end
    endtask

    task automatic test_random();
        logic [1:0] enc;
        int r;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NUM_SLV; i++)
                set_slave(i, $urandom_range(0, 4), 8'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));
            r = $urandom_range(0, 9);
            enc = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b11 : 2'b00;
            do_xfer($sformatf("rand%0d", t), enc, 8'($urandom), 8'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_waits();
        test_back_to_back();
        test_pslverr();
        test_timeout();
        test_illegal();
        test_reset_mid_access();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/apb_master_multi.md
Name: apb_master_multi

Overview:
Parametrised APB4 master. Takes single-transfer requests from a local command port (valid/ready handshake) and drives them onto an APB bus shared by NUM_SLV slaves. Each slave gets its own one-hot PSEL, decoded from the top address bits. Adds features the single-slave master lacks: byte strobes, PSLVERR capture, a wait-state timeout with abort, back-to-back transfers without an idle cycle, and a registered response channel.

Parameters:
ADDR_W, 8, address width (paddr, trf_addr)
DATA_W, 8, data width; must be a multiple of 8
NUM_SLV, 4, number of APB slaves; legal values 1, 2, 4, 8
TIMEOUT, 16, maximum ACCESS cycles before abort; 0 disables the timeout

Ports:
pclk  in  1  clock; all logic on the rising edge
prst  in  1  reset, synchronous, active-high
trf_valid  in  1  request valid
trf_ready  out  1  request accepted when trf_valid & trf_ready at a rising edge
trf_enc  in  2  2'b01 write, 2'b10 read; other encodings are illegal
trf_addr  in  ADDR_W  request address
trf_wdata  in  DATA_W  write data
trf_strb  in  DATA_W/8  write byte strobes
trf_rsp_valid  out  1  one-cycle response pulse
trf_rsp_err  out  1  response error (pslverr, timeout, or illegal enc)
trf_rdata  out  DATA_W  read data, qualified by trf_rsp_valid
psel  out  NUM_SLV  one-hot slave select
penable  out  1  APB enable
paddr  out  ADDR_W  APB address
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
pstrb  out  DATA_W/8  APB strobes; forced to 0 for reads
prdata  in  NUM_SLV*DATA_W  flattened read data; slave i occupies bits [i*DATA_W +: DATA_W]
pready  in  NUM_SLV  per-slave ready
pslverr  in  NUM_SLV  per-slave error

Behaviour:
- Reset (prst=1 at an edge): state IDLE. psel, penable, paddr, pwrite, pwdata, pstrb, trf_rsp_valid, trf_rsp_err, trf_rdata all 0. An in-flight transfer is dropped with no response.
- Slave decode:
  - SLV_W = log2(NUM_SLV).
  - idx = trf_addr[ADDR_W-1 -: SLV_W], latched at accept.
  - NUM_SLV=1: idx = 0.
  - pready, pslverr and prdata are taken from slave idx only.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE:
    - trf_ready=1.
    - On accept with legal enc: latch addr, wdata, strb, enc and idx; go to SETUP.
    - On accept with illegal enc: no bus activity; next cycle trf_rsp_valid=1, trf_rsp_err=1, trf_rdata=0; stay IDLE.
  - SETUP:
    - psel[idx]=1, penable=0, paddr/pwrite/pwdata/pstrb valid.
    - Always go to ACCESS next.
  - ACCESS:
    - psel[idx]=1, penable=1.
    - All bus outputs held stable from SETUP.
    - Wait-cycle counter increments each cycle pready[idx]=0.
    - Complete when pready[idx]=1.
- Completion (sampled in ACCESS):
  - Next cycle: trf_rsp_valid=1 for one cycle.
  - trf_rsp_err = pslverr[idx].
  - Read: trf_rdata = prdata[idx].
  - Write: trf_rdata = 0.
- Back-to-back:
  - In ACCESS, trf_ready = pready[idx]. This is a combinational path from pready, and it is intentional.
  - If a request is accepted on the completion edge, go straight to SETUP. There is no IDLE cycle and psel may change slave.
  - Otherwise go to IDLE, with psel=0 and penable=0.
- Timeout (TIMEOUT>0):
  - If the counter reaches TIMEOUT while still in ACCESS without pready, abort: psel=0, penable=0, state IDLE.
  - Next cycle: trf_rsp_valid=1, trf_rsp_err=1, trf_rdata=0.
  - trf_ready=0 on the abort cycle.
  - The counter clears on entry to SETUP.
- Latency with zero wait states:
  - Accept at edge N.
  - SETUP in cycle N+1.
  - ACCESS in cycle N+2.
  - Response in cycle N+3.
  - Each wait state adds 1 cycle.
- Bus outputs keep their last value in IDLE except psel and penable. Reads drive pstrb=0.

Test Plan:
- Write, zero wait: addr=8'h05 (slave 0), wdata=8'hA5, strb=1 -> psel=4'b0001 for 2 cycles; penable high in the 2nd; pwrite=1, pwdata=8'hA5; response 3 cycles after accept, err=0, rdata=0.
- Read with 3 wait states: addr=8'hC2 (slave 3), slave returns 8'h3C -> psel=4'b1000; penable held 4 cycles; pstrb=0; trf_rdata=8'h3C, err=0.
- Back-to-back write to 8'h41 then read of 8'h81 with trf_valid held high -> second SETUP immediately after first ACCESS, no IDLE cycle; psel goes 4'b0010 then 4'b0100; two responses.
- pslverr: write to slave 2 with pslverr=1 at pready -> trf_rsp_err=1; FSM returns to IDLE normally.
- Timeout: TIMEOUT=16, slave never asserts pready -> abort after 16 ACCESS cycles; psel=0; response err=1; next request proceeds normally.
- Illegal enc 2'b11 -> no psel activity; err response next cycle. Separately, assert prst in mid-ACCESS -> all outputs 0 next cycle and no response.
